// File: rtl/ddr5_phy_frequency_ratio.sv
// rtl/ddr5_phy_frequency_ratio.sv - DFI 1:N frequency-ratio converter
// Serializes MC phases onto the PHY lane and gathers read beats / alert_n into phase words.
module ddr5_phy_frequency_ratio #(
  parameter int pNUM_RANK  = 1,
  parameter int pDRAM_SIZE = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [1:0]                dfi_freq_ratio_i,
  input  logic [pNUM_RANK-1:0]      dfi_cs_n_p0_i,
  input  logic [pNUM_RANK-1:0]      dfi_cs_n_p1_i,
  input  logic [pNUM_RANK-1:0]      dfi_cs_n_p2_i,
  input  logic [pNUM_RANK-1:0]      dfi_cs_n_p3_i,
  input  logic [pNUM_RANK-1:0]      dfi_reset_n_p0_i,
  input  logic [pNUM_RANK-1:0]      dfi_reset_n_p1_i,
  input  logic [pNUM_RANK-1:0]      dfi_reset_n_p2_i,
  input  logic [pNUM_RANK-1:0]      dfi_reset_n_p3_i,
  input  logic [13:0]               dfi_address_p0_i,
  input  logic [13:0]               dfi_address_p1_i,
  input  logic [13:0]               dfi_address_p2_i,
  input  logic [13:0]               dfi_address_p3_i,
  input  logic                      dfi_wrdata_en_p0_i,
  input  logic                      dfi_wrdata_en_p1_i,
  input  logic                      dfi_wrdata_en_p2_i,
  input  logic                      dfi_wrdata_en_p3_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p0_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p1_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p2_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_p3_i,
  input  logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p0_i,
  input  logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p1_i,
  input  logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p2_i,
  input  logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_p3_i,
  input  logic [2*pDRAM_SIZE-1:0]   dfi_rddata_i,
  input  logic                      dfi_rddata_valid_i,
  input  logic                      dfi_alert_n_i,
  output logic [pNUM_RANK-1:0]      dfi_cs_n_o,
  output logic [pNUM_RANK-1:0]      dfi_reset_n_o,
  output logic [13:0]               dfi_address_o,
  output logic                      dfi_wrdata_en_o,
  output logic [2*pDRAM_SIZE-1:0]   dfi_wrdata_o,
  output logic [pDRAM_SIZE/4-1:0]   dfi_wrdata_mask_o,
  output logic [2*pDRAM_SIZE-1:0]   dfi_rddata_w0_o,
  output logic [2*pDRAM_SIZE-1:0]   dfi_rddata_w1_o,
  output logic [2*pDRAM_SIZE-1:0]   dfi_rddata_w2_o,
  output logic [2*pDRAM_SIZE-1:0]   dfi_rddata_w3_o,
  output logic                      dfi_rddata_valid_w0_o,
  output logic                      dfi_rddata_valid_w1_o,
  output logic                      dfi_rddata_valid_w2_o,
  output logic                      dfi_rddata_valid_w3_o,
  output logic                      dfi_alert_n_a0_o,
  output logic                      dfi_alert_n_a1_o,
  output logic                      dfi_alert_n_a2_o,
  output logic                      dfi_alert_n_a3_o
);

  localparam int DW = 2 * pDRAM_SIZE;
  localparam int MW = pDRAM_SIZE / 4;

  logic [pNUM_RANK-1:0] cs_n_ph    [4];
  logic [pNUM_RANK-1:0] reset_n_ph [4];
  logic [13:0]          addr_ph    [4];
  logic [3:0]           wren_ph;
  logic [DW-1:0]        wrdata_ph  [4];
  logic [MW-1:0]        mask_ph    [4];

  logic [1:0]    ratio_q;
  logic [1:0]    last;
  logic          ratio_chg;
  logic [1:0]    ph;
  logic [1:0]    rd_cnt;
  logic [DW-1:0] rbuf [4];
  logic [DW-1:0] word [4];
  logic [3:0]    word_valid;
  logic [3:0]    abuf;
  logic [3:0]    alert_q;

  assign cs_n_ph[0]    = dfi_cs_n_p0_i;
  assign cs_n_ph[1]    = dfi_cs_n_p1_i;
  assign cs_n_ph[2]    = dfi_cs_n_p2_i;
  assign cs_n_ph[3]    = dfi_cs_n_p3_i;
  assign reset_n_ph[0] = dfi_reset_n_p0_i;
  assign reset_n_ph[1] = dfi_reset_n_p1_i;
  assign reset_n_ph[2] = dfi_reset_n_p2_i;
  assign reset_n_ph[3] = dfi_reset_n_p3_i;
  assign addr_ph[0]    = dfi_address_p0_i;
  assign addr_ph[1]    = dfi_address_p1_i;
  assign addr_ph[2]    = dfi_address_p2_i;
  assign addr_ph[3]    = dfi_address_p3_i;
  assign wren_ph       = {dfi_wrdata_en_p3_i, dfi_wrdata_en_p2_i,
                          dfi_wrdata_en_p1_i, dfi_wrdata_en_p0_i};
  assign wrdata_ph[0]  = dfi_wrdata_p0_i;
  assign wrdata_ph[1]  = dfi_wrdata_p1_i;
  assign wrdata_ph[2]  = dfi_wrdata_p2_i;
  assign wrdata_ph[3]  = dfi_wrdata_p3_i;
  assign mask_ph[0]    = dfi_wrdata_mask_p0_i;
  assign mask_ph[1]    = dfi_wrdata_mask_p1_i;
  assign mask_ph[2]    = dfi_wrdata_mask_p2_i;
  assign mask_ph[3]    = dfi_wrdata_mask_p3_i;

  // Reserved ratio code 11 behaves as 1:4.
  always_comb begin
    case (dfi_freq_ratio_i)
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
  end

  assign ratio_chg = (dfi_freq_ratio_i != ratio_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ratio_q <= 2'b00;
      ph      <= 2'd0;
    end else begin
      ratio_q <= dfi_freq_ratio_i;
      if (!enable_i || ratio_chg || ph >= last)
        ph <= 2'd0;
      else
        ph <= ph + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dfi_cs_n_o        <= '1;
      dfi_reset_n_o     <= '0;
      dfi_address_o     <= '0;
      dfi_wrdata_en_o   <= 1'b0;
      dfi_wrdata_o      <= '0;
      dfi_wrdata_mask_o <= '0;
    end else if (enable_i) begin
      dfi_cs_n_o        <= cs_n_ph[ph];
      dfi_reset_n_o     <= reset_n_ph[ph];
      dfi_address_o     <= addr_ph[ph];
      dfi_wrdata_en_o   <= wren_ph[ph];
      dfi_wrdata_o      <= wrdata_ph[ph];
      dfi_wrdata_mask_o <= mask_ph[ph];
    end else begin
      // Idle: deselect, no write, but DRAM reset_n still follows the MC.
      dfi_cs_n_o      <= '1;
      dfi_wrdata_en_o <= 1'b0;
      dfi_reset_n_o   <= dfi_reset_n_p0_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt     <= 2'd0;
      word_valid <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        rbuf[k] <= '0;
        word[k] <= '0;
      end
    end else begin
      word_valid <= 4'b0000;
      if (!enable_i || ratio_chg || !dfi_rddata_valid_i) begin
        rd_cnt <= 2'd0;
      end else begin
        rbuf[rd_cnt] <= dfi_rddata_i;
        if (rd_cnt == last) begin
          // Final beat bypasses the buffer so the word emerges one clock after it.
          for (int k = 0; k < 4; k++) begin
            if (2'(k) < last)
              word[k] <= rbuf[k];
            else if (2'(k) == last)
              word[k] <= dfi_rddata_i;
            else
              word[k] <= '0;
            word_valid[k] <= (2'(k) <= last);
          end
          rd_cnt <= 2'd0;
        end else begin
          rd_cnt <= rd_cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abuf    <= 4'b1111;
      alert_q <= 4'b1111;
    end else if (!enable_i) begin
      alert_q <= 4'b1111;
    end else begin
      abuf[ph] <= dfi_alert_n_i;
      if (ph == last) begin
        for (int k = 0; k < 4; k++) begin
          if (2'(k) < last)
            alert_q[k] <= abuf[k];
          else if (2'(k) == last)
            alert_q[k] <= dfi_alert_n_i;
          else
            alert_q[k] <= 1'b1;
        end
      end
    end
  end

  assign dfi_rddata_w0_o       = word[0];
  assign dfi_rddata_w1_o       = word[1];
  assign dfi_rddata_w2_o       = word[2];
  assign dfi_rddata_w3_o       = word[3];
  assign dfi_rddata_valid_w0_o = word_valid[0];
  assign dfi_rddata_valid_w1_o = word_valid[1];
  assign dfi_rddata_valid_w2_o = word_valid[2];
  assign dfi_rddata_valid_w3_o = word_valid[3];
  assign dfi_alert_n_a0_o      = alert_q[0];
  assign dfi_alert_n_a1_o      = alert_q[1];
  assign dfi_alert_n_a2_o      = alert_q[2];
  assign dfi_alert_n_a3_o      = alert_q[3];

endmodule

// File: tb/tb_ddr5_phy_frequency_ratio.sv
// tb/tb_ddr5_phy_frequency_ratio.sv - scoreboard bench for the DFI frequency-ratio converter
module tb_ddr5_phy_frequency_ratio;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  ratio = 2'b10;
  logic [0:0]  cs_n_p0 = 1'b0, cs_n_p1 = 1'b1, cs_n_p2 = 1'b1, cs_n_p3 = 1'b1;
  logic [0:0]  rstn_p0 = 1'b1, rstn_p1 = 1'b1, rstn_p2 = 1'b1, rstn_p3 = 1'b1;
  logic [13:0] addr_p0 = '0, addr_p1 = '0, addr_p2 = '0, addr_p3 = '0;
  logic        wren_p0 = 1'b1, wren_p1 = 1'b1, wren_p2 = 1'b1, wren_p3 = 1'b1;
  logic [15:0] wd_p0 = 16'h0100, wd_p1 = 16'h0101, wd_p2 = 16'h0102, wd_p3 = 16'h0103;
  logic [1:0]  wm_p0 = 2'd0, wm_p1 = 2'd1, wm_p2 = 2'd2, wm_p3 = 2'd3;
  logic [15:0] rddata = '0;
  logic        rvalid = 1'b0;
  logic        alert_n = 1'b1;

  logic [0:0]  cs_n_o, rstn_o;
  logic [13:0] addr_o;
  logic        wren_o;
  logic [15:0] wd_o;
  logic [1:0]  wm_o;
  logic [15:0] w0, w1, w2, w3;
  logic        v0, v1, v2, v3;
  logic        a0, a1, a2, a3;

  ddr5_phy_frequency_ratio #(.pNUM_RANK(1), .pDRAM_SIZE(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .dfi_freq_ratio_i(ratio),
    .dfi_cs_n_p0_i(cs_n_p0), .dfi_cs_n_p1_i(cs_n_p1), .dfi_cs_n_p2_i(cs_n_p2), .dfi_cs_n_p3_i(cs_n_p3),
    .dfi_reset_n_p0_i(rstn_p0), .dfi_reset_n_p1_i(rstn_p1), .dfi_reset_n_p2_i(rstn_p2), .dfi_reset_n_p3_i(rstn_p3),
    .dfi_address_p0_i(addr_p0), .dfi_address_p1_i(addr_p1), .dfi_address_p2_i(addr_p2), .dfi_address_p3_i(addr_p3),
    .dfi_wrdata_en_p0_i(wren_p0), .dfi_wrdata_en_p1_i(wren_p1), .dfi_wrdata_en_p2_i(wren_p2), .dfi_wrdata_en_p3_i(wren_p3),
    .dfi_wrdata_p0_i(wd_p0), .dfi_wrdata_p1_i(wd_p1), .dfi_wrdata_p2_i(wd_p2), .dfi_wrdata_p3_i(wd_p3),
    .dfi_wrdata_mask_p0_i(wm_p0), .dfi_wrdata_mask_p1_i(wm_p1), .dfi_wrdata_mask_p2_i(wm_p2), .dfi_wrdata_mask_p3_i(wm_p3),
    .dfi_rddata_i(rddata), .dfi_rddata_valid_i(rvalid), .dfi_alert_n_i(alert_n),
    .dfi_cs_n_o(cs_n_o), .dfi_reset_n_o(rstn_o), .dfi_address_o(addr_o),
    .dfi_wrdata_en_o(wren_o), .dfi_wrdata_o(wd_o), .dfi_wrdata_mask_o(wm_o),
    .dfi_rddata_w0_o(w0), .dfi_rddata_w1_o(w1), .dfi_rddata_w2_o(w2), .dfi_rddata_w3_o(w3),
    .dfi_rddata_valid_w0_o(v0), .dfi_rddata_valid_w1_o(v1),
    .dfi_rddata_valid_w2_o(v2), .dfi_rddata_valid_w3_o(v3),
    .dfi_alert_n_a0_o(a0), .dfi_alert_n_a1_o(a1), .dfi_alert_n_a2_o(a2), .dfi_alert_n_a3_o(a3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] w3, w2, w1, w0;
  } rd_exp_t;

  rd_exp_t     rd_q [$];
  logic [14:0] wq [$];
  rd_exp_t     mon_e;
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] d);
    rddata = d;
    rvalid = 1'b1;
    tick();
  endtask

  task automatic wr_step(input logic [14:0] exp);
    wq.push_back(exp);
    tick();
    check("wr_cs_addr", 64'({cs_n_o, addr_o}), 64'(wq.pop_front()));
  endtask

  // Read-word monitor: every valid pulse must match the oldest queued burst.
  always @(negedge clk) begin
    if ({v3, v2, v1, v0} != 4'b0000) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'({v3, v2, v1, v0}), 64'h0);
      end else begin
        mon_e = rd_q.pop_front();
        check("rd_valid", 64'({v3, v2, v1, v0}), 64'(mon_e.v));
        check("rd_w0", 64'(w0), 64'(mon_e.w0));
        check("rd_w1", 64'(w1), 64'(mon_e.w1));
        check("rd_w2", 64'(w2), 64'(mon_e.w2));
        check("rd_w3", 64'(w3), 64'(mon_e.w3));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_cs_n", 64'(cs_n_o), 64'h1);
    check("rst_reset_n", 64'(rstn_o), 64'h0);
    check("rst_addr", 64'(addr_o), 64'h0);
    check("rst_wren", 64'(wren_o), 64'h0);
    check("rst_valid", 64'({v3, v2, v1, v0}), 64'h0);
    check("rst_alert", 64'({a3, a2, a1, a0}), 64'hF);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    // 1:4 command serialization, new phase set loaded at ph=0
    addr_p0 = 14'd1; addr_p1 = 14'd2; addr_p2 = 14'd3; addr_p3 = 14'd4;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        addr_p0 = 14'hA; addr_p1 = 14'hB; addr_p2 = 14'hC; addr_p3 = 14'hD;
      end
      case (i % 4)
        0: wr_step({1'b0, (i < 4) ? 14'd1 : 14'hA});
        1: wr_step({1'b1, (i < 4) ? 14'd2 : 14'hB});
        2: wr_step({1'b1, (i < 4) ? 14'd3 : 14'hC});
        default: wr_step({1'b1, (i < 4) ? 14'd4 : 14'hD});
      endcase
    end

    // 1:4 full read burst, then a stray beat
    beat(16'hAAAA);
    beat(16'hBBBB);
    beat(16'hCCCC);
    rd_q.push_back({4'b1111, 16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA});
    beat(16'hDDDD);
    beat(16'h1111);
    rvalid = 1'b0;
    tick();
    tick();
    check("rd_hold_w0", 64'(w0), 64'hAAAA);
    check("rd_hold_w3", 64'(w3), 64'hDDDD);

    // partial burst discarded, next burst starts at w0
    beat(16'h1111);
    beat(16'h2222);
    rvalid = 1'b0;
    tick();
    beat(16'h3333);
    beat(16'h4444);
    beat(16'h5555);
    rd_q.push_back({4'b1111, 16'h6666, 16'h5555, 16'h4444, 16'h3333});
    beat(16'h6666);
    rvalid = 1'b0;
    tick();
    tick();

    // disabled outputs, then 1:4 alert gathering aligned to ph=0
    enable = 1'b0;
    tick();
    tick();
    check("dis_alert", 64'({a3, a2, a1, a0}), 64'hF);
    check("dis_cs_n", 64'(cs_n_o), 64'h1);
    check("dis_wren", 64'(wren_o), 64'h0);
    enable = 1'b1;
    alert_n = 1'b0; tick();
    alert_n = 1'b1; tick();
    alert_n = 1'b0; tick();
    check("alert_early", 64'({a3, a2, a1, a0}), 64'hF);
    alert_n = 1'b1; tick();
    check("alert_word", 64'({a3, a2, a1, a0}), 64'b1010);

    // 1:2 mode
    enable = 1'b0;
    ratio = 2'b01;
    tick();
    tick();
    addr_p0 = 14'd5; addr_p1 = 14'd6; addr_p2 = 14'd7; addr_p3 = 14'd8;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) wr_step({1'b0, 14'd5});
      else wr_step({1'b1, 14'd6});
    end
    beat(16'h1234);
    rd_q.push_back({4'b0011, 16'h0000, 16'h0000, 16'h5678, 16'h1234});
    beat(16'h5678);
    rvalid = 1'b0;
    tick();
    tick();

    // asynchronous reset in the middle of a 1:4 burst
    enable = 1'b0;
    ratio = 2'b10;
    tick();
    tick();
    enable = 1'b1;
    beat(16'h7777);
    beat(16'h8888);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_addr", 64'(addr_o), 64'h0);
    check("mid_rst_cs_n", 64'(cs_n_o), 64'h1);
    check("mid_rst_reset_n", 64'(rstn_o), 64'h0);
    check("mid_rst_w0", 64'(w0), 64'h0);
    check("mid_rst_w1", 64'(w1), 64'h0);
    check("mid_rst_valid", 64'({v3, v2, v1, v0}), 64'h0);
    rvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    beat(16'h9999);
    beat(16'hAAAA);
    beat(16'hBBBB);
    rd_q.push_back({4'b1111, 16'hCCCC, 16'hBBBB, 16'hAAAA, 16'h9999});
    beat(16'hCCCC);
    rvalid = 1'b0;
    tick();
    tick();

    check("rd_pending", 64'(rd_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
